interrupt_break: RTL and testbench
==================================

Name: interrupt_break

Overview:
- Interrupt-entry sequencer directly downstream of the IOT 600x interrupt decoder.
- Holds the master interrupt-enable flag (ION), driven by the decoder's set/clear pulses, and applies the PDP-8 one-instruction ION delay.
- At an instruction boundary with ION on and a device request pending, it performs the break: writes PC to location 0000, then forces PC to 0001.
- Also supplies the ion and int_req status bits used by the SKON and SRQ skips.

Parameters:
NIRQ, 8, number of device interrupt request lines
VEC_SAVE, 12'o0000, address the interrupted PC is written to
VEC_JUMP, 12'o0001, PC value loaded after the save

Ports:
CLK  input  1  system clock, all state on rising edge
clear  input  1  synchronous active-high reset
ion_set  input  1  one-cycle pulse: ION executed
ion_clr  input  1  one-cycle pulse: IOF, CAF or SKON-taken executed
irq  input  NIRQ  level device requests, CLK-synchronous
instr_done  input  1  one-cycle pulse in last cycle of every instruction
pc  input  12  PC of next instruction, valid when instr_done=1
mem_ack  input  1  memory write complete
ion  output  1  interrupt enable flag
int_req  output  1  OR of irq (SRQ skip source)
brk_req  output  1  break in progress; CPU must not start fetch
mem_we  output  1  memory write strobe
mem_addr  output  12  write address
mem_data  output  12  write data (saved PC)
pc_load  output  1  one-cycle PC load strobe
pc_val  output  12  value for PC load

Behaviour:
- Reset (clear=1 at a clock edge): state=IDLE, ion=0, dly=0, pc latch=0; all outputs 0 except int_req.
- clear overrides every other input, including mid-break: the break is abandoned and no pc_load occurs.
- int_req = |irq. It is combinational and valid during reset.
- ION flag, state IDLE only:
  - ion_set: ion<=1, dly<=1.
  - ion_clr: ion<=0, dly<=0.
  - Both in the same cycle: ion_set wins.
  - ion_set/ion_clr are ignored outside IDLE.
- Delay flag dly, IDLE only, on instr_done:
  - If dly=1: dly<=0 and no break this boundary. This covers the ION instruction's own end.
  - If ion_set and instr_done coincide: ion<=1, dly<=0, no break.
- Break condition, evaluated in IDLE at a cycle T with instr_done=1: ion=1 AND dly=0 AND ion_set=0 AND |irq=1. ion_clr=1 in the same cycle suppresses the break.
- On break at T: pc latch<=pc, ion<=0, state<=SAVE (effective at T+1).
- States:
  - IDLE: brk_req=0, mem_we=0, pc_load=0.
  - SAVE: brk_req=1, mem_we=1, mem_addr=VEC_SAVE, mem_data=pc latch. Held until mem_ack=1 is sampled, then ->JUMP. mem_ack outside SAVE is ignored.
  - JUMP: brk_req=1, mem_we=0, pc_load=1, pc_val=VEC_JUMP, for exactly one cycle, then ->IDLE.
- Latency: with mem_ack already high, instr_done at T gives mem_we during T+1 and pc_load during T+2; brk_req falls at T+3.
- instr_done outside IDLE is ignored (it cannot occur; not an error).
- irq dropping during SAVE/JUMP does not abort the break.
- ion stays 0 after the break until software executes ION. The break clears ION, so there is no re-entry.
- mem_addr, mem_data and pc_val are 0 whenever their strobe is low.

Test Plan:
- Reset mid-SAVE: clear while mem_we=1 -> next cycle state IDLE, mem_we=0, brk_req=0, ion=0, no pc_load ever follows.
- ION delay: ion_set, instr_done(pc=0200) with irq[3]=1, then instr_done(pc=0201) -> no break at the first boundary; at the second, mem_we with mem_addr=0000, mem_data=0201, then pc_load with pc_val=0001, ion=0.
- Ack wait: break with mem_ack held low 5 cycles -> mem_we and brk_req held for exactly those cycles plus the ack cycle; pc_load fires once, the cycle after mem_ack.
- Priority: ion_set and ion_clr in the same cycle -> ion=1. ion_clr coincident with a qualifying instr_done -> no break, ion=0.
- No request: ion=1, dly=0, irq=0 across 3 instr_done pulses -> brk_req stays 0, int_req=0. Then raising irq[7] -> int_req=1 in the same cycle; the break starts at the next instr_done.
- Coincident set+boundary: ion_set with instr_done and irq=1 -> no break that boundary, ion=1. The next instr_done triggers the break.

Source files
------------

// File: rtl/interrupt_break.sv
// Interrupt-entry sequencer: owns the ION flag with its one-instruction delay and
// runs the break (save PC to VEC_SAVE, then load PC with VEC_JUMP).
module interrupt_break #(
  parameter int          NIRQ     = 8,
  parameter logic [11:0] VEC_SAVE = 12'o0000,
  parameter logic [11:0] VEC_JUMP = 12'o0001
) (
  input  logic            CLK,
  input  logic            clear,
  input  logic            ion_set,
  input  logic            ion_clr,
  input  logic [NIRQ-1:0] irq,
  input  logic            instr_done,
  input  logic [11:0]     pc,
  input  logic            mem_ack,
  output logic            ion,
  output logic            int_req,
  output logic            brk_req,
  output logic            mem_we,
  output logic [11:0]     mem_addr,
  output logic [11:0]     mem_data,
  output logic            pc_load,
  output logic [11:0]     pc_val
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SAVE = 2'd1,
    S_JUMP = 2'd2
  } state_t;

  state_t r_state;
  logic   r_dly;
  logic   w_any_irq;

  assign w_any_irq = |irq;
  assign int_req   = w_any_irq;

  // mem_data doubles as the PC latch: it holds the saved PC only while the
  // write strobe is up and is cleared when the save completes.
  always_ff @(posedge CLK) begin
    if (clear) begin
      r_state  <= S_IDLE;
      r_dly    <= 1'b0;
      ion      <= 1'b0;
      brk_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 12'd0;
      mem_data <= 12'd0;
      pc_load  <= 1'b0;
      pc_val   <= 12'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ion_set) begin
            // ION coinciding with a boundary is that instruction's own end
            ion   <= 1'b1;
            r_dly <= ~instr_done;
          end else if (ion_clr) begin
            ion   <= 1'b0;
            r_dly <= 1'b0;
          end else if (instr_done) begin
            if (r_dly) begin
              r_dly <= 1'b0;
            end else if (ion && w_any_irq) begin
              ion      <= 1'b0;
              r_state  <= S_SAVE;
              brk_req  <= 1'b1;
              mem_we   <= 1'b1;
              mem_addr <= VEC_SAVE;
              mem_data <= pc;
            end
          end
        end
        S_SAVE: begin
          if (mem_ack) begin
            r_state  <= S_JUMP;
            mem_we   <= 1'b0;
            mem_addr <= 12'd0;
            mem_data <= 12'd0;
            pc_load  <= 1'b1;
            pc_val   <= VEC_JUMP;
          end
        end
        S_JUMP: begin
          r_state <= S_IDLE;
          brk_req <= 1'b0;
          pc_load <= 1'b0;
          pc_val  <= 12'd0;
        end
        default: begin
          r_state  <= S_IDLE;
          brk_req  <= 1'b0;
          mem_we   <= 1'b0;
          mem_addr <= 12'd0;
          mem_data <= 12'd0;
          pc_load  <= 1'b0;
          pc_val   <= 12'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_break.sv
// Directed bench for interrupt_break; expected saved-PC values go through a
// scoreboard queue and are popped when the DUT raises its memory write.
module tb_interrupt_break;

  logic        CLK = 1'b0;
  logic        clear;
  logic        ion_set;
  logic        ion_clr;
  logic [7:0]  irq;
  logic        instr_done;
  logic [11:0] pc;
  logic        mem_ack;
  logic        ion;
  logic        int_req;
  logic        brk_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [11:0] mem_data;
  logic        pc_load;
  logic [11:0] pc_val;

  int checks = 0;
  int errors = 0;
  logic [11:0] sb[$];

  interrupt_break #(.NIRQ(8), .VEC_SAVE(12'o0000), .VEC_JUMP(12'o0001)) dut (
    .CLK(CLK), .clear(clear), .ion_set(ion_set), .ion_clr(ion_clr), .irq(irq),
    .instr_done(instr_done), .pc(pc), .mem_ack(mem_ack), .ion(ion),
    .int_req(int_req), .brk_req(brk_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .pc_load(pc_load), .pc_val(pc_val)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called on the first SAVE cycle; ack arrives in SAVE cycle number d.
  task automatic run_break(input int d, input string tag);
    logic [11:0] exp;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 12'd1, 12'd0);
      exp = 12'd0;
    end else begin
      exp = sb.pop_front();
    end
    for (int i = 0; i <= d; i++) begin
      mem_ack = (i == d);
      chk({tag, "_mem_we"}, mem_we, 1'b1);
      chk({tag, "_brk"}, brk_req, 1'b1);
      chk({tag, "_addr"}, mem_addr, 12'o0000);
      chk({tag, "_data"}, mem_data, exp);
      chk({tag, "_early_load"}, pc_load, 1'b0);
      tick();
    end
    mem_ack = 1'b1;
    chk({tag, "_pc_load"}, pc_load, 1'b1);
    chk({tag, "_pc_val"}, pc_val, 12'o0001);
    chk({tag, "_we_off"}, mem_we, 1'b0);
    chk({tag, "_data_off"}, mem_data, 12'd0);
    chk({tag, "_brk_jump"}, brk_req, 1'b1);
    tick();
    chk({tag, "_brk_end"}, brk_req, 1'b0);
    chk({tag, "_load_end"}, pc_load, 1'b0);
    chk({tag, "_ion_after"}, ion, 1'b0);
  endtask

  task automatic pulse_done(input logic [11:0] p);
    pc = p;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
  endtask

  task automatic enable_ion();
    ion_set = 1'b1;
    tick();
    ion_set = 1'b0;
    pulse_done(12'o0100);
  endtask

  initial begin
    clear = 1'b1; ion_set = 1'b0; ion_clr = 1'b0; irq = 8'h00;
    instr_done = 1'b0; pc = 12'd0; mem_ack = 1'b1;
    tick(); tick();
    chk("rst_ion", ion, 1'b0);
    chk("rst_brk", brk_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_load", pc_load, 1'b0);
    chk("rst_pcval", pc_val, 12'd0);
    irq = 8'h01; #1;
    chk("rst_int_req", int_req, 1'b1);
    irq = 8'h00; #1;
    chk("rst_int_req_low", int_req, 1'b0);
    clear = 1'b0;

    // ION delay: first boundary after ION is the ION instruction itself
    ion_set = 1'b1; tick(); ion_set = 1'b0;
    chk("dly_ion", ion, 1'b1);
    irq = 8'h08;
    pulse_done(12'o0200);
    chk("dly_no_brk", brk_req, 1'b0);
    chk("dly_no_we", mem_we, 1'b0);
    sb.push_back(12'o0201);
    pulse_done(12'o0201);
    chk("dly_ion_clr", ion, 1'b0);
    run_break(0, "dly");
    pulse_done(12'o0202);
    chk("noreentry_brk", brk_req, 1'b0);

    // Ack wait of 5 cycles
    enable_ion();
    sb.push_back(12'o0300);
    pulse_done(12'o0300);
    run_break(5, "ackwait");

    // Priority
    ion_set = 1'b1; ion_clr = 1'b1; tick(); ion_set = 1'b0; ion_clr = 1'b0;
    chk("prio_set_wins", ion, 1'b1);
    pulse_done(12'o0400);
    ion_clr = 1'b1; pc = 12'o0401; instr_done = 1'b1; tick();
    ion_clr = 1'b0; instr_done = 1'b0;
    chk("prio_clr_ion", ion, 1'b0);
    chk("prio_clr_nobrk", brk_req, 1'b0);
    tick();
    chk("prio_clr_nowe", mem_we, 1'b0);

    // No request across three boundaries
    irq = 8'h00;
    enable_ion();
    for (int k = 0; k < 3; k++) begin
      pulse_done(12'o0500 + 12'(k));
      chk("noreq_brk", brk_req, 1'b0);
      chk("noreq_int_req", int_req, 1'b0);
    end
    irq = 8'h80; #1;
    chk("noreq_int_req_rise", int_req, 1'b1);
    sb.push_back(12'o1234);
    pulse_done(12'o1234);
    irq = 8'h00;
    run_break(0, "irq7");

    // Coincident ion_set and boundary
    irq = 8'h01;
    ion_set = 1'b1; pc = 12'o0600; instr_done = 1'b1; tick();
    ion_set = 1'b0; instr_done = 1'b0;
    chk("coinc_ion", ion, 1'b1);
    chk("coinc_nobrk", brk_req, 1'b0);
    sb.push_back(12'o4567);
    pulse_done(12'o4567);
    irq = 8'h00;
    run_break(0, "coinc");

    // Reset mid-SAVE abandons the break
    irq = 8'h02;
    enable_ion();
    pc = 12'o0777; instr_done = 1'b1; mem_ack = 1'b0; tick(); instr_done = 1'b0;
    chk("rsave_we", mem_we, 1'b1);
    clear = 1'b1; tick(); clear = 1'b0; mem_ack = 1'b1;
    chk("rsave_we_off", mem_we, 1'b0);
    chk("rsave_brk_off", brk_req, 1'b0);
    chk("rsave_ion", ion, 1'b0);
    chk("rsave_data", mem_data, 12'd0);
    for (int k = 0; k < 4; k++) begin
      chk("rsave_no_load", pc_load, 1'b0);
      tick();
    end
    irq = 8'h00;

    chk("sb_drained", 12'(sb.size()), 12'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
